// File: rtl/ext_irq_gw.sv
// ext_irq_gw: external-interrupt gateway / arbiter (PLIC-lite).
// Synchronizes SRC_NUM device lines, keeps per-source IDLE/PEND/INFL state,
// picks the highest-priority enabled pending source above threshold and
// drives ext_irq. Software claims (read 0x8C) and completes (write 0x8C).
// Optional build macro EXT_IRQ_EDGE_EN: edge-triggered sources with a
// per-source retrigger flag; without it sources are level-triggered.
module ext_irq_gw #(
  parameter int SRC_NUM = 8,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [SRC_NUM-1:0] src_irq,
  output logic               ext_irq,
  input  logic               reg_vld,
  input  logic               reg_wr,
  input  logic [7:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic               reg_rvld
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_INFL = 2'd2;

  localparam logic [7:0] A_PEND = 8'h80;
  localparam logic [7:0] A_EN   = 8'h84;
  localparam logic [7:0] A_THR  = 8'h88;
  localparam logic [7:0] A_CLM  = 8'h8C;

  // Index i of every per-source array holds ID i+1.
  logic [SRC_NUM-1:0] r_s1, r_s2;
  logic [1:0]         r_st   [SRC_NUM];
  logic [PRIO_W-1:0]  r_prio [SRC_NUM];
  logic [SRC_NUM-1:0] r_en;
  logic [PRIO_W-1:0]  r_thr;
  logic [4:0]         r_best_id;
  logic [PRIO_W-1:0]  r_best_prio;
  logic               r_claim_busy;
  logic [31:0]        r_rdata;
  logic               r_rvld;

  logic               w_rd, w_wr, w_claim_ok, w_cmpl;
  logic [SRC_NUM-1:0] w_set, w_pend, w_claim_hit, w_cmpl_hit;
  logic [4:0]         w_arb_id;
  logic [PRIO_W-1:0]  w_arb_prio;
  logic [31:0]        w_rdata;
  logic               w_unused;

  assign w_rd       = reg_vld & ~reg_wr;
  assign w_wr       = reg_vld &  reg_wr;
  // A claim right after another sees a stale arbiter result; it returns 0.
  assign w_claim_ok = w_rd & (reg_addr == A_CLM) & ~r_claim_busy;
  assign w_cmpl     = w_wr & (reg_addr == A_CLM);
  assign w_unused   = ^{reg_wdata, r_best_prio};

`ifdef EXT_IRQ_EDGE_EN
  logic [SRC_NUM-1:0] r_s3, r_retrig;
  assign w_set = r_s2 & ~r_s3;
`else
  assign w_set = r_s2;
`endif

  // Two-flop synchronizer (plus edge-history flop in edge mode)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
`ifdef EXT_IRQ_EDGE_EN
      r_s3 <= '0;
`endif
    end else begin
      r_s1 <= src_irq;
      r_s2 <= r_s1;
`ifdef EXT_IRQ_EDGE_EN
      r_s3 <= r_s2;
`endif
    end
  end

  // Per-source claim/complete hit decode and pending view
  always_comb begin
    w_claim_hit = '0;
    w_cmpl_hit  = '0;
    w_pend      = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      w_claim_hit[i] = w_claim_ok && (r_best_id == 5'(i + 1));
      w_cmpl_hit[i]  = w_cmpl && (reg_wdata[4:0] == 5'(i + 1));
      w_pend[i]      = (r_st[i] == ST_PEND);
    end
  end

  // Gateway state per source; claim has precedence over a new pending-set
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SRC_NUM; i++) r_st[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < SRC_NUM; i++) begin
        case (r_st[i])
          ST_IDLE: if (w_set[i]) r_st[i] <= ST_PEND;
          ST_PEND: if (w_claim_hit[i]) r_st[i] <= ST_INFL;
          ST_INFL: if (w_cmpl_hit[i])
`ifdef EXT_IRQ_EDGE_EN
                     r_st[i] <= (r_retrig[i] | w_set[i]) ? ST_PEND : ST_IDLE;
`else
                     r_st[i] <= ST_IDLE;
`endif
          default: r_st[i] <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef EXT_IRQ_EDGE_EN
  // Retrigger flag remembers an edge seen while the source was busy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_retrig <= '0;
    end else begin
      for (int i = 0; i < SRC_NUM; i++) begin
        if (r_st[i] == ST_INFL && w_cmpl_hit[i]) r_retrig[i] <= 1'b0;
        else if (w_set[i] && r_st[i] != ST_IDLE) r_retrig[i] <= 1'b1;
      end
    end
  end
`endif

  // Configuration register writes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SRC_NUM; i++) r_prio[i] <= '0;
      r_en  <= '0;
      r_thr <= '0;
    end else if (w_wr) begin
      for (int i = 0; i < SRC_NUM; i++)
        if (reg_addr == 8'((i + 1) * 4)) r_prio[i] <= reg_wdata[PRIO_W-1:0];
      if (reg_addr == A_EN)  r_en  <= reg_wdata[SRC_NUM:1];
      if (reg_addr == A_THR) r_thr <= reg_wdata[PRIO_W-1:0];
    end
  end

  // Arbiter: strict '>' while scanning upward keeps the lowest ID on ties
  always_comb begin
    w_arb_id   = '0;
    w_arb_prio = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (w_pend[i] && r_en[i] && (r_prio[i] > r_thr) && (r_prio[i] > w_arb_prio)) begin
        w_arb_id   = 5'(i + 1);
        w_arb_prio = r_prio[i];
      end
    end
  end

  // Registered arbiter result and post-claim guard
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_best_id    <= '0;
      r_best_prio  <= '0;
      r_claim_busy <= 1'b0;
    end else begin
      r_best_id    <= w_arb_id;
      r_best_prio  <= w_arb_prio;
      r_claim_busy <= w_claim_ok;
    end
  end

  // Read data mux
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < SRC_NUM; i++)
      if (reg_addr == 8'((i + 1) * 4)) w_rdata[PRIO_W-1:0] = r_prio[i];
    case (reg_addr)
      A_PEND:  w_rdata[SRC_NUM:1] = w_pend;
      A_EN:    w_rdata[SRC_NUM:1] = r_en;
      A_THR:   w_rdata[PRIO_W-1:0] = r_thr;
      A_CLM:   w_rdata[4:0] = w_claim_ok ? r_best_id : 5'd0;
      default: ;
    endcase
  end

  // Read response register, one-cycle valid pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rdata <= '0;
      r_rvld  <= 1'b0;
    end else begin
      r_rvld <= w_rd;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  assign reg_rdata = r_rdata;
  assign reg_rvld  = r_rvld;
  assign ext_irq   = (r_best_id != 5'd0) & ~r_claim_busy;
endmodule

// File: tb/tb_ext_irq_gw.sv
// tb_ext_irq_gw: directed scenarios plus random traffic, every cycle checked
// against a cycle-level reference model of the gateway/arbiter behaviour.
module tb_ext_irq_gw;
  localparam int N  = 8;
  localparam int PW = 3;

  logic         clk = 1'b0, rstn = 1'b0;
  logic [N-1:0] src_irq = '0;
  logic         ext_irq;
  logic         reg_vld = 1'b0, reg_wr = 1'b0;
  logic [7:0]   reg_addr = '0;
  logic [31:0]  reg_wdata = '0;
  logic [31:0]  reg_rdata;
  logic         reg_rvld;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  ext_irq_gw #(.SRC_NUM(N), .PRIO_W(PW)) dut (
    .clk(clk), .rstn(rstn), .src_irq(src_irq), .ext_irq(ext_irq),
    .reg_vld(reg_vld), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_rvld(reg_rvld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference model state
  bit           m_pend [1:N], m_infl [1:N], m_retrig [1:N], m_en [1:N];
  int           m_prio [1:N];
  int           m_thr, m_best;
  bit           m_busy;
  logic [N-1:0] m_s1, m_s2, m_prev;
  bit           e_rvld;
  logic [31:0]  e_rdata;

  task automatic model_reset();
    for (int id = 1; id <= N; id++) begin
      m_pend[id] = 0; m_infl[id] = 0; m_retrig[id] = 0; m_en[id] = 0; m_prio[id] = 0;
    end
    m_thr = 0; m_best = 0; m_busy = 0;
    m_s1 = '0; m_s2 = '0; m_prev = '0;
    e_rvld = 0; e_rdata = '0;
  endtask

  function automatic bit cand(input int id);
    return m_pend[id] && m_en[id] && (m_prio[id] > m_thr);
  endfunction

  // Highest priority first, then the lowest ID holding that priority
  function automatic int arb();
    int top = 0;
    for (int id = 1; id <= N; id++) if (cand(id) && m_prio[id] > top) top = m_prio[id];
    if (top == 0) return 0;
    for (int id = 1; id <= N; id++) if (cand(id) && m_prio[id] == top) return id;
    return 0;
  endfunction

  function automatic logic [31:0] read_val(input logic [7:0] a);
    logic [31:0] v = '0;
    if (a[1:0] == 2'b00 && a >= 8'd4 && int'(a) <= 4 * N) return 32'(m_prio[a / 4]);
    case (a)
      8'h80: for (int id = 1; id <= N; id++) v[id] = m_pend[id];
      8'h84: for (int id = 1; id <= N; id++) v[id] = m_en[id];
      8'h88: v = 32'(m_thr);
      8'h8C: v = m_busy ? 32'd0 : 32'(m_best);
      default: v = '0;
    endcase
    return v;
  endfunction

  // One clock edge of the reference, using the inputs present at that edge
  task automatic model_step();
    bit op [1:N], oi [1:N], orr [1:N];
    bit cl, cp;
    int cid, nb;
    logic [N-1:0] rise;
    op = m_pend; oi = m_infl; orr = m_retrig;
    e_rvld = reg_vld && !reg_wr;
    if (e_rvld) e_rdata = read_val(reg_addr);
    nb   = arb();
    cl   = reg_vld && !reg_wr && reg_addr == 8'h8C && !m_busy;
    cp   = reg_vld && reg_wr && reg_addr == 8'h8C;
    cid  = int'(reg_wdata[4:0]);
    rise = m_s2 & ~m_prev;
    for (int id = 1; id <= N; id++) begin
`ifdef EXT_IRQ_EDGE_EN
      if (!op[id] && !oi[id] && rise[id-1]) m_pend[id] = 1;
      else if (rise[id-1]) m_retrig[id] = 1;
`else
      if (!op[id] && !oi[id] && m_s2[id-1]) m_pend[id] = 1;
`endif
      if (cl && m_best == id && op[id]) begin m_pend[id] = 0; m_infl[id] = 1; end
      if (cp && cid == id && oi[id]) begin
        m_infl[id] = 0;
`ifdef EXT_IRQ_EDGE_EN
        if (orr[id] || rise[id-1]) m_pend[id] = 1;
        m_retrig[id] = 0;
`endif
      end
    end
    if (reg_vld && reg_wr) begin
      if (reg_addr[1:0] == 2'b00 && reg_addr >= 8'd4 && int'(reg_addr) <= 4 * N)
        m_prio[reg_addr / 4] = int'(reg_wdata[PW-1:0]);
      if (reg_addr == 8'h84) for (int id = 1; id <= N; id++) m_en[id] = reg_wdata[id];
      if (reg_addr == 8'h88) m_thr = int'(reg_wdata[PW-1:0]);
    end
    m_best = nb;
    m_busy = cl;
    m_prev = m_s2; m_s2 = m_s1; m_s1 = src_irq;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (!rstn) model_reset(); else model_step();
    chk("ext_irq", 32'(ext_irq), 32'(m_best != 0 && !m_busy));
    chk("rvld", 32'(reg_rvld), 32'(e_rvld));
    if (e_rvld) chk("rdata", reg_rdata, e_rdata);
    @(negedge clk);
    reg_vld = 1'b0; reg_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_vld = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_vld = 1'b1; reg_wr = 1'b0; reg_addr = a;
    tick();
    d = reg_rdata;
  endtask

  task automatic do_reset(input logic [N-1:0] s);
    rstn = 1'b0; src_irq = s;
    idle(2);
    rstn = 1'b1;
  endtask

  logic [31:0] d;
  int pick;

  initial begin
    model_reset();
    @(negedge clk);

    // Reset with all sources asserted
    do_reset('1);
    rd(8'h80, d); chk("rst_pend", d, 0);
    rd(8'h84, d); chk("rst_en", d, 0);
    rd(8'h88, d); chk("rst_thr", d, 0);
    rd(8'h04, d); chk("rst_prio1", d, 0);
    idle(4); chk("rst_noirq", 32'(ext_irq), 0);

    // Single source latency and claim
    do_reset('0);
    wr(8'h0C, 2); wr(8'h84, 32'h08); wr(8'h88, 1);
    src_irq[2] = 1'b1;
    tick(); chk("lat_e1", 32'(ext_irq), 0);
    tick(); chk("lat_e2", 32'(ext_irq), 0);
    tick(); chk("lat_e3", 32'(ext_irq), 0);
    tick(); chk("lat_e4", 32'(ext_irq), 1);
    rd(8'h8C, d); chk("claim3", d, 3); chk("irq_drop", 32'(ext_irq), 0);
    src_irq[2] = 1'b0;
    wr(8'h8C, 3); idle(3);

    // Priority ordering and tie-break
    do_reset('0);
    wr(8'h08, 5); wr(8'h14, 5); wr(8'h18, 7); wr(8'h84, 32'h64);
    src_irq = 8'h32; idle(5);
    rd(8'h8C, d); chk("claim6", d, 6);
    rd(8'h8C, d); chk("claim_b2b", d, 0);
    idle(1);
    rd(8'h8C, d); chk("claim2", d, 2);
    idle(1);
    rd(8'h8C, d); chk("claim5", d, 5);
    src_irq = '0; idle(2);

    // Threshold boundary
    do_reset('0);
    wr(8'h04, 5); wr(8'h84, 32'h02); wr(8'h88, 5);
    src_irq = 8'h01; idle(5);
    chk("thr_eq", 32'(ext_irq), 0);
    wr(8'h88, 4); chk("thr_w0", 32'(ext_irq), 0);
    tick(); chk("thr_w1", 32'(ext_irq), 1);
    src_irq = '0; idle(2);

`ifndef EXT_IRQ_EDGE_EN
    // Level re-pend after complete; bogus completes ignored
    do_reset('0);
    wr(8'h10, 1); wr(8'h84, 32'h10);
    src_irq = 8'h08; idle(5);
    rd(8'h8C, d); chk("claim4", d, 4);
    rd(8'h80, d); chk("infl_pend", d, 0);
    wr(8'h8C, 4); idle(1);
    rd(8'h80, d); chk("repend", d, 32'h10);
    idle(1);
    rd(8'h8C, d); chk("claim4b", d, 4);
    wr(8'h8C, 9); wr(8'h8C, 0);
    rd(8'h80, d); chk("bad_cmpl", d, 0);
    src_irq = '0; wr(8'h8C, 4); idle(3);
`else
    // Edge pulse and retrigger while in flight
    do_reset('0);
    wr(8'h08, 3); wr(8'h84, 32'h04);
    src_irq[1] = 1'b1; tick(); src_irq[1] = 1'b0; idle(4);
    rd(8'h8C, d); chk("edge_claim", d, 2);
    src_irq[1] = 1'b1; tick(); src_irq[1] = 1'b0; idle(3);
    rd(8'h80, d); chk("edge_infl", d, 0);
    wr(8'h8C, 2); idle(1);
    rd(8'h80, d); chk("retrig", d, 32'h04);
    rd(8'h8C, d); chk("edge_claim2", d, 2);
    wr(8'h8C, 2); idle(3);
`endif

    // Async reset while a claim response is in flight
    do_reset('0);
    wr(8'h04, 1); wr(8'h84, 32'h02);
    src_irq = 8'h01; idle(5);
    reg_vld = 1'b1; reg_wr = 1'b0; reg_addr = 8'h8C;
    @(posedge clk); #2;
    rstn = 1'b0; #1;
    chk("rstmid_rvld", 32'(reg_rvld), 0);
    chk("rstmid_rdata", reg_rdata, 0);
    chk("rstmid_irq", 32'(ext_irq), 0);
    model_reset();
    @(negedge clk); reg_vld = 1'b0;
    src_irq = '0; idle(1); rstn = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(7) == 0) begin
        pick = int'($urandom_range(N - 1));
        src_irq[pick] = ~src_irq[pick];
      end
      case ($urandom_range(9))
        0: wr(8'(4 * $urandom_range(1, N)), $urandom);
        1: wr(8'h84, $urandom);
        2: wr(8'h88, 32'($urandom_range(3)));
        3, 4: rd(8'h8C, d);
        5, 6: begin
          pick = int'($urandom_range(31));
          for (int id = 1; id <= N; id++) if (m_infl[id] && $urandom_range(1) == 1) pick = id;
          wr(8'h8C, 32'(pick));
        end
        7: rd(8'($urandom_range(255)), d);
        8: rd(8'h80, d);
        default: tick();
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
